gpo_tx_queue: RTL and testbench

Parametrised parallel-output transmitter that queues words from the core and presents each one on a GPO bus with an active-low INTR strobe to the external receiver. It replaces the single-word, fire-once transmitter with a configurable-width bus, a DEPTH-entry FIFO, a programmable strobe width and an optional receiver-acknowledge handshake with timeout. It sits between the processing core and the board-level GPO pins.

---
 rtl/gpo_tx_queue.sv | 168 ++++++++++++++++
 tb/tb_gpo_tx_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpo_tx_queue.sv
// rtl/gpo_tx_queue.sv - queued parallel-output transmitter with active-low INTR strobe.
// Optional receiver-acknowledge handshake with timeout is enabled by defining GPO_TX_ACK_EN.
module gpo_tx_queue #(
  parameter int  DATA_W      = 23,
  parameter int  DEPTH       = 4,
  parameter int  PULSE_W     = 1,
  parameter int  ACK_TIMEOUT = 255,
  localparam int LVL_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_to_send,
  input  logic              start_send,
  input  logic              ack,
  output logic [DATA_W-1:0] GPO,
  output logic              INTR,
  output logic              ready,
  output logic              busy,
  output logic              full,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic              timeout
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT_ACK,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [7:0]          pulse_cnt_q, pulse_cnt_d;
  logic [DATA_W-1:0]   gpo_q;
  logic                intr_q, ready_q, busy_q, full_q, overflow_q, timeout_q;
  logic                push, pop, timeout_d;

`ifdef GPO_TX_ACK_EN
  logic [15:0]         ack_cnt_q, ack_cnt_d;
`else
  logic                unused_ack;
  assign unused_ack = ack;
`endif

  // Fullness is taken from the registered flag, so a same-cycle pop never rescues a push.
  assign push = start_send && !full_q;

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    pop         = 1'b0;
    timeout_d   = 1'b0;
    level_d     = level_q;
`ifdef GPO_TX_ACK_EN
    ack_cnt_d   = ack_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d     = S_STROBE;
        pulse_cnt_d = '0;
      end
      S_STROBE: begin
        if (pulse_cnt_q == 8'(PULSE_W - 1)) begin
`ifdef GPO_TX_ACK_EN
          state_d   = S_WAIT_ACK;
          ack_cnt_d = '0;
`else
          state_d   = S_DONE;
`endif
        end else begin
          pulse_cnt_d = pulse_cnt_q + 8'd1;
        end
      end
      S_WAIT_ACK: begin
`ifdef GPO_TX_ACK_EN
        // ack takes priority over the final timeout cycle.
        if (ack) begin
          state_d = S_DONE;
        end else if (ack_cnt_q == 16'(ACK_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 16'd1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_to_send;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pulse_cnt_q <= '0;
      gpo_q       <= '0;
      intr_q      <= 1'b1;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef GPO_TX_ACK_EN
      ack_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      pulse_cnt_q <= pulse_cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        gpo_q    <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      // Outputs are registered from next-state values so they line up with the state.
      intr_q      <= (state_d != S_STROBE);
      ready_q     <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE) || (level_d != '0);
      full_q      <= (level_d == LVL_W'(DEPTH));
      overflow_q  <= start_send && full_q;
      timeout_q   <= timeout_d;
`ifdef GPO_TX_ACK_EN
      ack_cnt_q   <= ack_cnt_d;
`endif
    end
  end

  assign GPO      = gpo_q;
  assign INTR     = intr_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign full     = full_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_gpo_tx_queue.sv
// tb/tb_gpo_tx_queue.sv - directed self-checking bench for gpo_tx_queue.
module tb_gpo_tx_queue;

  localparam int DW = 23;
`ifdef GPO_TX_ACK_EN
  localparam int WX = 1;
`else
  localparam int WX = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: PULSE_W=1, ack tied high
  logic          a_rst, a_start;
  logic [DW-1:0] a_data, a_gpo;
  logic          a_intr, a_ready, a_busy, a_full, a_ovf, a_to;
  logic [2:0]    a_level;

  // Instance B: PULSE_W=5, ack tied high
  logic          b_rst, b_start;
  logic [DW-1:0] b_data, b_gpo;
  logic          b_intr, b_ready, b_busy, b_full, b_ovf, b_to;
  logic [2:0]    b_level;

  // Instance C: PULSE_W=1, ACK_TIMEOUT=10, driven ack
  logic          c_rst, c_start, c_ack;
  logic [DW-1:0] c_data, c_gpo;
  logic          c_intr, c_ready, c_busy, c_full, c_ovf, c_to;
  logic [2:0]    c_level;

  gpo_tx_queue #(.DATA_W(DW), .DEPTH(4), .PULSE_W(1), .ACK_TIMEOUT(255)) u_a (
    .clk(clk), .reset(a_rst), .data_to_send(a_data), .start_send(a_start), .ack(1'b1),
    .GPO(a_gpo), .INTR(a_intr), .ready(a_ready), .busy(a_busy), .full(a_full),
    .level(a_level), .overflow(a_ovf), .timeout(a_to));

  gpo_tx_queue #(.DATA_W(DW), .DEPTH(4), .PULSE_W(5), .ACK_TIMEOUT(255)) u_b (
    .clk(clk), .reset(b_rst), .data_to_send(b_data), .start_send(b_start), .ack(1'b1),
    .GPO(b_gpo), .INTR(b_intr), .ready(b_ready), .busy(b_busy), .full(b_full),
    .level(b_level), .overflow(b_ovf), .timeout(b_to));

  gpo_tx_queue #(.DATA_W(DW), .DEPTH(4), .PULSE_W(1), .ACK_TIMEOUT(10)) u_c (
    .clk(clk), .reset(c_rst), .data_to_send(c_data), .start_send(c_start), .ack(c_ack),
    .GPO(c_gpo), .INTR(c_intr), .ready(c_ready), .busy(c_busy), .full(c_full),
    .level(c_level), .overflow(c_ovf), .timeout(c_to));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] seen [$];
    int ovf_cnt, rdy_cnt, intr_cnt, run, maxrun, first_low, bad, low_total;
    logic prev_intr;

    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0; c_ack = 1'b0;
    a_data = '0; b_data = '0; c_data = '0;
    tick; tick;
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    check("rst_gpo",   a_gpo,   0);
    check("rst_intr",  a_intr,  1);
    check("rst_ready", a_ready, 0);
    check("rst_busy",  a_busy,  0);
    check("rst_full",  a_full,  0);
    check("rst_level", a_level, 0);
    check("rst_ovf",   a_ovf,   0);
    check("rst_to",    a_to,    0);

    // Single word, PULSE_W=1
    a_data = 23'h5A5A5A; a_start = 1'b1;
    tick;
    a_start = 1'b0;
    check("t1_level1", a_level, 1);
    check("t1_busy1",  a_busy,  1);
    tick;
    check("t1_gpo",    a_gpo,   32'h5A5A5A);
    check("t1_setup_intr", a_intr, 1);
    tick;
    check("t1_strobe", a_intr,  0);
    tick;
    check("t1_intr_hi", a_intr, 1);
    repeat (WX) tick;
    check("t1_ready",  a_ready, 1);
    tick;
    check("t1_ready0", a_ready, 0);
    check("t1_idle",   a_busy,  0);

    // Burst of six: the sixth hits a full FIFO and is dropped despite a same-cycle pop
    ovf_cnt = 0; rdy_cnt = 0; intr_cnt = 0; prev_intr = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (i < 6) begin
        a_start = 1'b1;
        a_data  = DW'(i + 1);
      end else begin
        a_start = 1'b0;
      end
      tick;
      if (i == 4) begin
        check("t2_full",  a_full,  1);
        check("t2_lvl4",  a_level, 4);
      end
      if (i == 5) begin
        check("t2_ovf",     a_ovf,   1);
        check("t2_ovf_lvl", a_level, (WX == 1) ? 4 : 3);
      end
      if (a_ovf) ovf_cnt++;
      if (a_ready) begin
        rdy_cnt++;
        seen.push_back(32'(a_gpo));
      end
      if (!a_intr && prev_intr) intr_cnt++;
      prev_intr = a_intr;
    end
    check("t2_ovf_cnt",  ovf_cnt,  1);
    check("t2_rdy_cnt",  rdy_cnt,  5);
    check("t2_intr_cnt", intr_cnt, 5);
    for (int k = 0; k < 5; k++) begin
      check("t2_order", (k < seen.size()) ? seen[k] : 32'hDEAD, 32'(k + 1));
    end
    check("t2_last_gpo", a_gpo,   5);
    check("t2_drained",  a_level, 0);
    check("t2_busy",     a_busy,  0);

    // Strobe width, PULSE_W=5
    b_data = 23'h03C0F1; b_start = 1'b1;
    tick;
    b_start = 1'b0;
    run = 0; maxrun = 0; first_low = -1; bad = 0; low_total = 0; rdy_cnt = 0;
    for (int i = 1; i < 30; i++) begin
      tick;
      if (!b_intr) begin
        run++;
        low_total++;
        if (first_low < 0) first_low = i;
      end else begin
        run = 0;
      end
      if (run > maxrun) maxrun = run;
      if (b_gpo !== 23'h03C0F1) bad++;
      if (b_ready) rdy_cnt++;
    end
    check("t3_first_low", first_low, 2);
    check("t3_width",     maxrun,    5);
    check("t3_low_total", low_total, 5);
    check("t3_gpo_stable", bad,      0);
    check("t3_ready_cnt", rdy_cnt,   1);

    // Reset mid-STROBE with three words queued
    for (int i = 0; i < 4; i++) begin
      b_start = 1'b1;
      b_data  = DW'(32'h11 + i);
      tick;
    end
    b_start = 1'b0;
    check("t6_pre_lvl",  b_level, 3);
    check("t6_pre_intr", b_intr,  0);
    b_rst = 1'b1;
    tick;
    b_rst = 1'b0;
    check("t6_intr",  b_intr,  1);
    check("t6_level", b_level, 0);
    check("t6_gpo",   b_gpo,   0);
    check("t6_busy",  b_busy,  0);
    check("t6_full",  b_full,  0);
    rdy_cnt = 0; low_total = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (b_ready) rdy_cnt++;
      if (!b_intr) low_total++;
    end
    check("t6_no_ready", rdy_cnt,   0);
    check("t6_no_intr",  low_total, 0);

`ifdef GPO_TX_ACK_EN
    // Ack on the third WAIT_ACK cycle
    c_data = 23'h000ABC; c_start = 1'b1;
    tick;
    c_start = 1'b0;
    tick; tick; tick;
    check("t4_wait_intr", c_intr,  1);
    check("t4_wait_rdy",  c_ready, 0);
    tick;
    check("t4_wait2_rdy", c_ready, 0);
    tick;
    c_ack = 1'b1;
    tick;
    c_ack = 1'b0;
    check("t4_ready", c_ready, 1);
    check("t4_no_to", c_to,    0);
    tick;
    check("t4_ready0", c_ready, 0);
    tick;

    // Timeout after ten WAIT_ACK cycles, then the next word starts
    c_data = 23'h000111; c_start = 1'b1;
    tick;
    c_data = 23'h000222;
    tick;
    c_start = 1'b0;
    rdy_cnt = 0;
    for (int i = 2; i <= 13; i++) begin
      tick;
      if (c_ready) rdy_cnt++;
      if (i == 12) check("t5_to_early", c_to, 0);
      if (i == 13) check("t5_timeout",  c_to, 1);
    end
    check("t5_no_ready", rdy_cnt, 0);
    tick;
    check("t5_to_pulse", c_to,  0);
    check("t5_next_gpo", c_gpo, 32'h222);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
